// File: rtl/pipemdu_pkg.sv
// Shared definitions for the pipelined multiply/divide unit: op codes,
// FSM states, the last iteration index and an absolute-value helper.
package pipemdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  localparam logic [4:0] ITER_LAST = 5'd31;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/pipemdu_if.sv
// EXE-stage handshake between the pipeline (master) and the MDU (slave).
interface pipemdu_if;
  logic        estart;
  logic [2:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        emfreq;
  logic        emfsel;
  logic        ecancel;
  logic [31:0] ehilo;
  logic        stall;
  logic        busy;
  logic        edivz;

  modport master (
    output estart, eop, ea, eb, emfreq, emfsel, ecancel,
    input  ehilo, stall, busy, edivz
  );

  modport slave (
    input  estart, eop, ea, eb, emfreq, emfsel, ecancel,
    output ehilo, stall, busy, edivz
  );
endinterface

// File: rtl/pipemdu_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a
// restoring subtract-shift divide step on the {acc, q} register pair.
module mdu_step (
  input  logic        i_div,
  input  logic [31:0] i_acc,
  input  logic [31:0] i_q,
  input  logic [31:0] i_m,
  output logic [31:0] o_acc,
  output logic [31:0] o_q
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : 33'd0);
    w_shift = {i_acc, i_q[31]};
    w_diff  = w_shift - {1'b0, i_m};
    o_acc   = w_sum[32:1];
    o_q     = {w_sum[0], i_q[31:1]};
    if (i_div) begin
      // Bit 32 of the difference is the borrow: set means the trial subtract failed.
      if (!w_diff[32]) begin
        o_acc = w_diff[31:0];
        o_q   = {i_q[30:0], 1'b1};
      end else begin
        o_acc = w_shift[31:0];
        o_q   = {i_q[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pipemdu.sv
// Pipelined multiply/divide unit with HI/LO registers and pipeline stall.
// Optional MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module pipemdu
  import pipemdu_pkg::*;
(
  input  logic      clock,
  input  logic      resetn,
  pipemdu_if.slave  mdu
);

  mdu_state_e  r_state;
  mdu_state_e  w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_acc;
  logic [31:0] r_q;
  logic [31:0] r_m;
  logic        r_div;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_edivz;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_divz;
  logic        w_iter;
  logic [31:0] w_step_acc;
  logic [31:0] w_step_q;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_accept = mdu.estart && (mdu.eop != OP_NONE) && (r_state == ST_IDLE) && !mdu.ecancel;
  assign w_is_mul = (mdu.eop == OP_MULT) || (mdu.eop == OP_MULTU);
  assign w_is_div = (mdu.eop == OP_DIV)  || (mdu.eop == OP_DIVU);
  assign w_signed = (mdu.eop == OP_MULT) || (mdu.eop == OP_DIV);
  assign w_divz   = w_is_div && (mdu.eb == 32'd0);

`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  assign w_smul = 64'($signed(mdu.ea)) * 64'($signed(mdu.eb));
  assign w_umul = {32'd0, mdu.ea} * {32'd0, mdu.eb};
  assign w_iter = w_is_div && !w_divz;
`else
  assign w_iter = (w_is_mul || w_is_div) && !w_divz;
`endif

  mdu_step u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_m   (r_m),
    .o_acc (w_step_acc),
    .o_q   (w_step_q)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_iter) w_state_next = ST_RUN;
      ST_RUN: begin
        if (mdu.ecancel)             w_state_next = ST_IDLE;
        else if (r_cnt == ITER_LAST) w_state_next = ST_FIX;
      end
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sign correction: r_qneg covers the product or the quotient, r_rneg the remainder.
  always_comb begin
    w_prod   = {r_acc, r_q};
    if (r_qneg) w_prod = ~w_prod + 64'd1;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_div) begin
      w_fix_lo = r_qneg ? (~r_q + 32'd1)   : r_q;
      w_fix_hi = r_rneg ? (~r_acc + 32'd1) : r_acc;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_acc   <= 32'd0;
      r_q     <= 32'd0;
      r_m     <= 32'd0;
      r_div   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_edivz <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_edivz <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_iter) begin
              r_acc  <= 32'd0;
              r_q    <= abs32(mdu.ea, w_signed);
              r_m    <= abs32(mdu.eb, w_signed);
              r_div  <= w_is_div;
              r_qneg <= w_signed && (mdu.ea[31] ^ mdu.eb[31]);
              r_rneg <= w_signed && mdu.ea[31];
              r_cnt  <= 5'd0;
            end else if (w_divz) begin
              r_lo    <= 32'hFFFF_FFFF;
              r_hi    <= mdu.ea;
              r_edivz <= 1'b1;
`ifdef MDU_FAST_MUL_EN
            end else if (w_is_mul) begin
              {r_hi, r_lo} <= (mdu.eop == OP_MULT) ? w_smul : w_umul;
`endif
            end else if (mdu.eop == OP_MTHI) begin
              r_hi <= mdu.ea;
            end else if (mdu.eop == OP_MTLO) begin
              r_lo <= mdu.ea;
            end
          end
        end
        ST_RUN: begin
          if (!mdu.ecancel) begin
            r_acc <= w_step_acc;
            r_q   <= w_step_q;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_FIX: begin
          if (!mdu.ecancel) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.busy  = (r_state != ST_IDLE);
  assign mdu.stall = mdu.busy && (mdu.emfreq || (mdu.estart && (mdu.eop != OP_NONE)));
  assign mdu.ehilo = mdu.emfsel ? r_hi : r_lo;
  assign mdu.edivz = r_edivz;

endmodule

// File: tb/tb_pipemdu.sv
// Self-checking bench for pipemdu: directed corner cases plus random ops
// compared against an arithmetic HI/LO model.
module tb_pipemdu;
  import pipemdu_pkg::*;

  logic clock;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  pipemdu_if bus ();

  pipemdu dut (
    .clock  (clock),
    .resetn (resetn),
    .mdu    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Busy cycles per op: 32 RUN + 1 FIX for iterative ops, none otherwise.
  function automatic int model_cycles(input logic [2:0] op, input logic [31:0] b);
    if (op == OP_DIV || op == OP_DIVU) return (b == 32'd0) ? 0 : 33;
`ifdef MDU_FAST_MUL_EN
    if (op == OP_MULT || op == OP_MULTU) return 0;
`else
    if (op == OP_MULT || op == OP_MULTU) return 33;
`endif
    return 0;
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          p = 64'(sq);
          m_lo = p[31:0];
          p = 64'(sr);
          m_hi = p[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.emfsel = 1'b1;
    #1 hi = bus.ehilo;
    bus.emfsel = 1'b0;
    #1 lo = bus.ehilo;
  endtask

  // Entered and left shortly after a falling edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          exp_n;
    logic        exp_dz;
    logic [31:0] hi;
    logic [31:0] lo;
    exp_n  = model_cycles(op, b);
    exp_dz = (op == OP_DIV || op == OP_DIVU) && (b == 32'd0);
    bus.estart = 1'b1;
    bus.eop    = op;
    bus.ea     = a;
    bus.eb     = b;
    #1 check("accept_stall", 64'(bus.stall), 64'd0);
    model_apply(op, a, b);
    @(negedge clock);
    bus.estart = 1'b0;
    bus.eop    = OP_NONE;
    check("edivz", 64'(bus.edivz), 64'(exp_dz));
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("busy_cycles", 64'(n), 64'(exp_n));
    if (exp_dz) begin
      @(negedge clock);
      check("edivz_clear", 64'(bus.edivz), 64'd0);
    end
    read_hilo(hi, lo);
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", op, a, b, hi, lo, n);
  endtask

  initial begin
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    resetn      = 1'b0;
    bus.estart  = 1'b1;
    bus.eop     = OP_MULT;
    bus.ea      = 32'd5;
    bus.eb      = 32'd6;
    bus.emfreq  = 1'b1;
    bus.emfsel  = 1'b0;
    bus.ecancel = 1'b0;
    #2;
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_edivz", 64'(bus.edivz), 64'd0);
    bus.estart = 1'b0;
    bus.eop    = OP_NONE;
    bus.emfreq = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    read_hilo(hi, lo);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clock);
    bus.emfreq = 1'b1;
    #1 check("idle_mf_stall", 64'(bus.stall), 64'd0);
    bus.emfreq = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(OP_DIV, 32'd5, 32'd0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_MTHI, 32'h1234_5678, 32'd0);
    do_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    do_op(OP_MULT, 32'd6, 32'd7);

    // MFLO five cycles after a DIVU accept stalls until the result lands.
    @(negedge clock);
    bus.estart = 1'b1; bus.eop = OP_DIVU; bus.ea = 32'd100; bus.eb = 32'd7;
    model_apply(OP_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    bus.estart = 1'b0; bus.eop = OP_NONE;
    repeat (4) @(negedge clock);
    bus.emfreq = 1'b1; bus.emfsel = 1'b0;
    n = 0;
    #1;
    while (bus.stall && n < 100) begin
      @(negedge clock);
      #1 n++;
    end
    check("mflo_stall_cycles", 64'(n), 64'd29);
    check("mflo_value", 64'(bus.ehilo), 64'd14);
    bus.emfreq = 1'b0;
    $display("mflo after divu 100/7 stalled %0d cycles value=%0d", n, bus.ehilo);

    // An op held on the bus during a divide is accepted right after FIX.
    @(negedge clock);
    bus.estart = 1'b1; bus.eop = OP_DIVU; bus.ea = 32'd1000; bus.eb = 32'd3;
    model_apply(OP_DIVU, 32'd1000, 32'd3);
    @(negedge clock);
    bus.eop = OP_MTLO; bus.ea = 32'hCAFE_0001;
    n = 0;
    while (bus.stall && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("held_stall_cycles", 64'(n), 64'd33);
    model_apply(OP_MTLO, 32'hCAFE_0001, 32'd0);
    @(negedge clock);
    bus.estart = 1'b0; bus.eop = OP_NONE;
    check("held_busy", 64'(bus.busy), 64'd0);
    read_hilo(hi, lo);
    check("held_hi", 64'(hi), 64'(m_hi));
    check("held_lo", 64'(lo), 64'(m_lo));
    $display("held mtlo accepted after %0d stall cycles hi=%h lo=%h", n, hi, lo);

    // Cancel a MULTU at cycle 10, then a back-to-back DIVU.
    @(negedge clock);
    bus.estart = 1'b1; bus.eop = OP_MULTU; bus.ea = 32'hFFFF_FFFF; bus.eb = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.estart = 1'b0; bus.eop = OP_NONE;
    repeat (9) @(negedge clock);
`ifndef MDU_FAST_MUL_EN
    check("cancel_pre_busy", 64'(bus.busy), 64'd1);
`endif
    bus.ecancel = 1'b1;
    @(negedge clock);
    bus.ecancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
`ifdef MDU_FAST_MUL_EN
    model_apply(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif
    read_hilo(hi, lo);
    check("cancel_hi", 64'(hi), 64'(m_hi));
    check("cancel_lo", 64'(lo), 64'(m_lo));
    $display("cancel multu hi=%h lo=%h", hi, lo);
    do_op(OP_DIVU, 32'hDEAD_BEEF, 32'd13);

    // ecancel in IDLE suppresses the accept.
    bus.estart = 1'b1; bus.eop = OP_MTHI; bus.ea = 32'h5555_AAAA; bus.ecancel = 1'b1;
    @(negedge clock);
    bus.estart = 1'b0; bus.eop = OP_NONE; bus.ecancel = 1'b0;
    read_hilo(hi, lo);
    check("idle_cancel_hi", 64'(hi), 64'(m_hi));
    $display("idle cancel mthi hi=%h", hi);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      @(negedge clock);
      do_op(op, a, b);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    bus.estart = 1'b1; bus.eop = OP_DIVU; bus.ea = 32'd77; bus.eb = 32'd5;
    @(negedge clock);
    bus.estart = 1'b0; bus.eop = OP_NONE;
    repeat (5) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rst_run_busy", 64'(bus.busy), 64'd0);
    check("rst_run_stall", 64'(bus.stall), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    read_hilo(hi, lo);
    check("rst_run_hi", 64'(hi), 64'd0);
    check("rst_run_lo", 64'(lo), 64'd0);
    $display("reset mid-run hi=%h lo=%h", hi, lo);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    do_op(OP_MULTU, 32'd123456, 32'd654321);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipemdu.md
PIPEMDU -- requirements
Module: pipemdu

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 estart  in  1  valid multiply/divide/move-to op present in EXE this cycle.
REQ-004 eop  in  3  op code: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
REQ-005 ea  in  32  operand A (rs) / dividend / MTHI-MTLO source.
REQ-006 eb  in  32  operand B (rt) / divisor.
REQ-007 emfreq  in  1  MFHI/MFLO present in EXE this cycle.
REQ-008 emfsel  in  1  0 = read LO, 1 = read HI.
REQ-009 ecancel  in  1  abort the in-flight op (exception flush).
REQ-010 ehilo  out  32  combinational HI or LO selected by emfsel.
REQ-011 stall  out  1  freeze IF/ID/EXE this cycle.
REQ-012 busy  out  1  iterative op in progress.
REQ-013 edivz  out  1  one-cycle pulse when a DIV/DIVU with eb = 0 is accepted.

Function
REQ-014 FSM states IDLE, RUN, FIX; IDLE -> RUN on accepted MULT/MULTU/DIV/DIVU; RUN -> FIX when the 5-bit iteration counter reaches 31; FIX -> IDLE unconditionally.
REQ-015 An op is accepted only when estart=1, eop is nonzero and the state is IDLE; accepting an op does not assert stall.
REQ-016 Accept cycle: latch |ea|, |eb| (signed ops) or raw values (unsigned ops); record result signs; clear the counter.
REQ-017 RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle; 32 steps total.
REQ-018 FIX: apply sign correction; write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder, remainder takes the sign of the dividend.
REQ-019 Latency: HI/LO hold the new value in the cycle after FIX; that is 34 cycles after the accept edge.
REQ-020 busy = 1 in RUN and FIX, 0 in IDLE.
REQ-021 stall = busy AND (emfreq OR (estart AND eop != 000)); stall is never asserted in IDLE.
REQ-022 A stalled op is re-presented by the pipeline and is accepted in the first IDLE cycle after FIX.
REQ-023 An emfreq coinciding with FIX stalls; the read in the following cycle returns the new value.
REQ-024 MTHI/MTLO accepted in IDLE write ea at the next edge, with no state change.
REQ-025 Divide by zero completes in 1 cycle with no RUN or FIX: LO = 32'hFFFFFFFF, HI = ea, edivz pulses; busy stays 0.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000 (wraps) and HI = 0; 0x80000000 is handled as an unsigned magnitude.
REQ-027 ecancel in RUN or FIX returns to IDLE at the next edge with HI/LO unchanged; ecancel in IDLE suppresses the accept in that cycle.

Reset
REQ-028 resetn low: state IDLE, counter 0, HI = LO = 0, busy = 0, stall = 0, edivz = 0; this also aborts any op in flight.

Configuration
REQ-029 With MDU_FAST_MUL_EN defined, MULT/MULTU compute the product combinationally and write HI/LO at the accept edge: no RUN/FIX, busy stays 0, latency 1. Divides remain iterative.
REQ-030 With MDU_FAST_MUL_EN undefined, multiplies follow REQ-014..REQ-019.

Structure
REQ-031 Shared package pipemdu_pkg holds the eop encodings, the FSM state enum and ITER_LAST = 31.
REQ-032 One sub-module mdu_step holds the single-cycle shift-add / restoring-divide datapath step; pipemdu holds the FSM, counter, sign logic and HI/LO registers.

Verification
REQ-033 MULT ea = 0xFFFFFFFE, eb = 3 -> busy for 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-034 DIVU ea = 100, eb = 7 -> LO = 14, HI = 2; an MFLO issued 5 cycles after accept stalls until FIX + 1 and then returns 14.
REQ-035 DIV ea = -7, eb = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV ea = 5, eb = 0 -> edivz pulses, LO = 0xFFFFFFFF, HI = 5, busy stays 0.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF, then ecancel at cycle 10 -> IDLE next cycle, HI/LO keep their prior values; a back-to-back DIVU is then accepted with no stall.
REQ-037 resetn pulsed low mid-RUN -> HI = LO = 0, busy = 0 immediately; with MDU_FAST_MUL_EN, MULT 6 x 7 -> LO = 42 one cycle after accept.
